// File: rtl/pb_fb_sdr_arbiter_pkg.sv
// Shared definitions for the SDRAM burst-port arbiter.
//   - FSM state and transfer-direction encodings
//   - default address / data widths and burst length
//   - helper that derives the burst direction from a master's request pair
package pb_fb_sdr_arbiter_pkg;

  localparam int DEF_CMD_ADDR_WIDTH = 23;
  localparam int DEF_NL_DW          = 16;
  localparam int DEF_BURST_LEN      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WE = 1'b1
  } dir_e;

  // Read wins when a master raises both requests; its write stays pending.
  function automatic dir_e req_dir(input logic rd_req);
    return rd_req ? DIR_RD : DIR_WE;
  endfunction

endpackage

// File: rtl/pb_fb_sdr_arbiter_if.sv
// Burst command port bundle, used both between a master and the arbiter and
// between the arbiter and the DRAM controller.
//   master modport : drives rd_req/we_req/addr/din, receives acks, dout,
//                    r_vld (read beat valid) and w_rdy (write beat taken)
//   slave  modport : the opposite side
interface pb_fb_sdr_arbiter_if
  import pb_fb_sdr_arbiter_pkg::*;
#(
  parameter int AW = DEF_CMD_ADDR_WIDTH,
  parameter int DW = DEF_NL_DW
);
  logic          rd_req;
  logic          we_req;
  logic          rd_ack;
  logic          we_ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          r_vld;
  logic          w_rdy;

  modport master (
    output rd_req, we_req, addr, din,
    input  rd_ack, we_ack, dout, r_vld, w_rdy
  );

  modport slave (
    input  rd_req, we_req, addr, din,
    output rd_ack, we_ack, dout, r_vld, w_rdy
  );
endinterface

// File: rtl/pb_fb_rr_arb2.sv
// Combinational two-way round-robin pick.
//   req  : request per master
//   last : index of the master granted most recently
//   vld  : at least one request present
//   gnt  : chosen master index (the one that is not `last` on a tie)
module pb_fb_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       vld,
  output logic       gnt
);

  assign vld = |req;

  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/pb_fb_sdr_arbiter.sv
// Two-master arbiter in front of the SDRAM controller burst command port.
// Master 0 is the L2 cache, master 1 a second burst master (DMA / fb reader).
// Grant is round-robin and held for a whole burst of BURST_LEN beats.
//   clk, rst_n : sdr_clk domain clock, async active-low reset
//   m0, m1     : master-facing burst ports (slave modport)
//   sdr        : DRAM-controller-facing burst port (master modport)
module pb_fb_sdr_arbiter
  import pb_fb_sdr_arbiter_pkg::*;
#(
  parameter int CMD_ADDR_WIDTH = DEF_CMD_ADDR_WIDTH,
  parameter int NL_DW          = DEF_NL_DW,
  parameter int BURST_LEN      = DEF_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pb_fb_sdr_arbiter_if.slave   m0,
  pb_fb_sdr_arbiter_if.slave   m1,
  pb_fb_sdr_arbiter_if.master  sdr
);

  localparam int              CNT_W     = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Master inputs gathered into vectors so the grant can index them.
  logic [1:0]                     rd_req_v, we_req_v;
  logic [1:0][CMD_ADDR_WIDTH-1:0] addr_v;
  logic [1:0][NL_DW-1:0]          din_v;

  assign rd_req_v = {m1.rd_req, m0.rd_req};
  assign we_req_v = {m1.we_req, m0.we_req};
  assign addr_v   = {m1.addr,   m0.addr};
  assign din_v    = {m1.din,    m0.din};

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q,  last_d;
  dir_e             dir_q,   dir_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic pick_vld, pick_gnt;

  pb_fb_rr_arb2 u_rr (
    .req  (rd_req_v | we_req_v),
    .last (last_q),
    .vld  (pick_vld),
    .gnt  (pick_gnt)
  );

  // Granted master's request / handshake of the latched direction.
  logic g_rd, g_we, g_req, g_ack, beat, in_cmd, in_xfer;

  assign g_rd    = rd_req_v[grant_q];
  assign g_we    = we_req_v[grant_q];
  assign g_req   = (dir_q == DIR_RD) ? g_rd : g_we;
  assign g_ack   = (dir_q == DIR_RD) ? sdr.rd_ack : sdr.we_ack;
  assign beat    = (dir_q == DIR_RD) ? sdr.r_vld  : sdr.w_rdy;
  assign in_cmd  = (state_q == ST_CMD);
  assign in_xfer = (state_q == ST_XFER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;   // master 0 wins the first tie
      dir_q      <= DIR_RD;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      dir_q      <= dir_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    dir_d      = dir_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          dir_d   = req_dir(rd_req_v[pick_gnt]);
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        // Fairness only advances once the burst is really accepted; an
        // aborted command leaves `last` alone.
        if (g_ack) begin
          state_d    = ST_XFER;
          beat_cnt_d = '0;
          last_d     = grant_q;
        end else if (!g_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Downstream side: command only in CMD, write data only in a write XFER.
  assign sdr.rd_req = in_cmd & (dir_q == DIR_RD) & g_rd;
  assign sdr.we_req = in_cmd & (dir_q == DIR_WE) & g_we;
  assign sdr.addr   = in_cmd ? addr_v[grant_q] : '0;
  assign sdr.din    = (in_xfer && dir_q == DIR_WE) ? din_v[grant_q] : '0;

  // Upstream side: handshakes steered to the granted master only.
  logic [1:0]       rd_ack_v, we_ack_v, r_vld_v, w_rdy_v;
  logic [NL_DW-1:0] dout_b;

  always_comb begin
    rd_ack_v = '0;
    we_ack_v = '0;
    r_vld_v  = '0;
    w_rdy_v  = '0;
    for (int n = 0; n < 2; n++) begin
      if (grant_q == 1'(n)) begin
        rd_ack_v[n] = in_cmd  & (dir_q == DIR_RD) & sdr.rd_ack;
        we_ack_v[n] = in_cmd  & (dir_q == DIR_WE) & sdr.we_ack;
        r_vld_v[n]  = in_xfer & (dir_q == DIR_RD) & sdr.r_vld;
        w_rdy_v[n]  = in_xfer & (dir_q == DIR_WE) & sdr.w_rdy;
      end
    end
  end

  // Read data is broadcast; gated so it reads 0 outside a read burst.
  assign dout_b = (in_xfer && dir_q == DIR_RD) ? sdr.dout : '0;

  assign m0.rd_ack = rd_ack_v[0];
  assign m0.we_ack = we_ack_v[0];
  assign m0.r_vld  = r_vld_v[0];
  assign m0.w_rdy  = w_rdy_v[0];
  assign m0.dout   = dout_b;
  assign m1.rd_ack = rd_ack_v[1];
  assign m1.we_ack = we_ack_v[1];
  assign m1.r_vld  = r_vld_v[1];
  assign m1.w_rdy  = w_rdy_v[1];
  assign m1.dout   = dout_b;

`ifndef SYNTHESIS
  a_ack_only_in_cmd: assert property (@(posedge clk) disable iff (!rst_n)
    (sdr.rd_ack || sdr.we_ack) |-> (state_q == ST_CMD));
  a_ack_dir: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_CMD) |-> !((dir_q == DIR_RD) ? sdr.we_ack : sdr.rd_ack));
  a_req_only_in_cmd: assert property (@(posedge clk) disable iff (!rst_n)
    (sdr.rd_req || sdr.we_req) |-> (state_q == ST_CMD));
  a_beat_only_in_xfer: assert property (@(posedge clk) disable iff (!rst_n)
    (sdr.r_vld || sdr.w_rdy) |-> (state_q == ST_XFER));
`endif

endmodule

// File: tb/tb_pb_fb_sdr_arbiter.sv
// Self-checking bench for pb_fb_sdr_arbiter. The bench plays both masters and
// the DRAM controller; a round-robin model (request shadow + last winner)
// predicts which master and direction each burst must get.
module tb_pb_fb_sdr_arbiter;
  import pb_fb_sdr_arbiter_pkg::*;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pb_fb_sdr_arbiter_if #(.AW(AW), .DW(DW)) m0 ();
  pb_fb_sdr_arbiter_if #(.AW(AW), .DW(DW)) m1 ();
  pb_fb_sdr_arbiter_if #(.AW(AW), .DW(DW)) sdr ();

  pb_fb_sdr_arbiter #(.CMD_ADDR_WIDTH(AW), .NL_DW(DW), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0),
    .m1    (m1),
    .sdr   (sdr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit            req_rd[2];
  bit            req_we[2];
  bit            mdl_last;
  logic [AW-1:0] maddr[2];
  int            lat;

  function automatic int pick();
    bit r0, r1;
    r0 = req_rd[0] | req_we[0];
    r1 = req_rd[1] | req_we[1];
    if (r0 && r1) return mdl_last ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  function automatic logic get_rd_ack(input int n); return (n == 1) ? m1.rd_ack : m0.rd_ack; endfunction
  function automatic logic get_we_ack(input int n); return (n == 1) ? m1.we_ack : m0.we_ack; endfunction
  function automatic logic get_r_vld (input int n); return (n == 1) ? m1.r_vld  : m0.r_vld;  endfunction
  function automatic logic get_w_rdy (input int n); return (n == 1) ? m1.w_rdy  : m0.w_rdy;  endfunction
  function automatic logic [DW-1:0] get_dout(input int n); return (n == 1) ? m1.dout : m0.dout; endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reqs();
    m0.rd_req = req_rd[0]; m0.we_req = req_we[0]; m0.addr = maddr[0];
    m1.rd_req = req_rd[1]; m1.we_req = req_we[1]; m1.addr = maddr[1];
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin req_rd[i] = 1'b0; req_we[i] = 1'b0; end
    apply_reqs();
    m0.din = '0; m1.din = '0;
    sdr.rd_ack = 1'b0; sdr.we_ack = 1'b0;
    sdr.dout = '0; sdr.r_vld = 1'b0; sdr.w_rdy = 1'b0;
  endtask

  // Waits (bounded) for a downstream command; lat = cycles waited.
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      #1;
      if (sdr.rd_req || sdr.we_req) seen = 1'b1;
      else begin tick(); lat++; end
    end
    chk("cmd_timeout", 32'(seen), 32'd1);
  endtask

  // One burst as the model predicts it: command, ack, nbeats beats.
  task automatic do_burst(input int nbeats, input bit drop, input bit fixed, input logic [DW-1:0] base);
    int            m;
    bit            rd, seen;
    logic [DW-1:0] data;
    m  = pick();
    rd = req_rd[m];
    wait_req(seen);
    if (!seen) return;
    chk("sdr_rd_req", 32'(sdr.rd_req), 32'(rd));
    chk("sdr_we_req", 32'(sdr.we_req), 32'(!rd));
    chk("sdr_addr",   32'(sdr.addr),   32'(maddr[m]));
    if (rd) sdr.rd_ack = 1'b1; else sdr.we_ack = 1'b1;
    #1;
    chk("ack_owner", 32'(rd ? get_rd_ack(m) : get_we_ack(m)), 32'd1);
    chk("ack_other", 32'(get_rd_ack(1 - m) | get_we_ack(1 - m)), 32'd0);
    tick();
    sdr.rd_ack = 1'b0; sdr.we_ack = 1'b0;
    mdl_last = m[0];
    if (drop) begin
      if (rd) req_rd[m] = 1'b0; else req_we[m] = 1'b0;
      apply_reqs();
    end
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, 2)) begin
        #1;
        chk("no_beat", 32'(get_r_vld(0) | get_r_vld(1) | get_w_rdy(0) | get_w_rdy(1)), 32'd0);
        tick();
      end
      data = fixed ? DW'(base + DW'(i)) : DW'($urandom);
      if (rd) begin
        sdr.r_vld = 1'b1; sdr.dout = data;
        #1;
        chk("rvld_owner", 32'(get_r_vld(m)),     32'd1);
        chk("rvld_other", 32'(get_r_vld(1 - m)), 32'd0);
        chk("dout",       32'(get_dout(m)),      32'(data));
      end else begin
        if (m == 1) begin m1.din = data; m0.din = ~data; end
        else        begin m0.din = data; m1.din = ~data; end
        sdr.w_rdy = 1'b1;
        #1;
        chk("sdr_din",    32'(sdr.din),          32'(data));
        chk("wrdy_owner", 32'(get_w_rdy(m)),     32'd1);
        chk("wrdy_other", 32'(get_w_rdy(1 - m)), 32'd0);
      end
      tick();
      sdr.r_vld = 1'b0; sdr.w_rdy = 1'b0;
    end
    if (nbeats == BL) begin
      #1;
      chk("gap_idle", 32'(sdr.rd_req | sdr.we_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    maddr[0] = AW'($urandom);
    maddr[1] = maddr[0] ^ AW'($urandom | 1);
    clear_inputs();
    // Reset state, with stimulus that must not leak through
    m0.rd_req = 1'b1; sdr.rd_ack = 1'b1; sdr.dout = 16'h55AA;
    #3;
    chk("rst_sdr_req",  32'(sdr.rd_req | sdr.we_req), 32'd0);
    chk("rst_ack",      32'(m0.rd_ack | m0.we_ack | m1.rd_ack | m1.we_ack), 32'd0);
    chk("rst_vld_rdy",  32'(m0.r_vld | m0.w_rdy | m1.r_vld | m1.w_rdy), 32'd0);
    chk("rst_addr",     32'(sdr.addr), 32'd0);
    chk("rst_din",      32'(sdr.din),  32'd0);
    chk("rst_dout",     32'(m0.dout),  32'd0);
    clear_inputs();
    tick(); tick();
    rst_n = 1'b1;
    mdl_last = 1'b1;

    // Same-cycle m0 read / m1 write after reset: m0 first, then m1
    req_rd[0] = 1'b1; req_we[1] = 1'b1; apply_reqs();
    do_burst(BL, 1'b1, 1'b0, '0);
    do_burst(BL, 1'b1, 1'b0, '0);

    // Both masters continuously requesting: grants alternate
    req_rd[0] = 1'b1; req_rd[1] = 1'b1; apply_reqs();
    for (int k = 0; k < 6; k++) do_burst(BL, k >= 4, 1'b0, '0);

    // Single m0 read with known address and data; one-cycle request latency
    maddr[0] = 23'h12345;
    req_rd[0] = 1'b1; apply_reqs();
    do_burst(BL, 1'b1, 1'b1, 16'hA000);
    chk("req_latency", 32'(lat), 32'd1);

    // m0 read+write together: read first, write on next arbitration
    req_rd[0] = 1'b1; req_we[0] = 1'b1; apply_reqs();
    do_burst(BL, 1'b1, 1'b0, '0);
    do_burst(BL, 1'b1, 1'b0, '0);

    // Abort: m1 wins (last=0), drops its write before ack; m0 follows
    maddr[1] = AW'($urandom) ^ 23'h1;
    req_rd[0] = 1'b1; req_we[1] = 1'b1; apply_reqs();
    wait_req(seen);
    chk("abort_we_req", 32'(sdr.we_req), 32'd1);
    chk("abort_addr",   32'(sdr.addr),   32'(maddr[1]));
    req_we[1] = 1'b0; apply_reqs();
    #1;
    chk("abort_no_ack", 32'(m1.we_ack | m1.rd_ack | m0.rd_ack | m0.we_ack), 32'd0);
    tick();
    #1;
    chk("abort_idle", 32'(sdr.rd_req | sdr.we_req), 32'd0);
    do_burst(BL, 1'b1, 1'b0, '0);

    // Reset in the middle of a read burst
    maddr[0] = AW'($urandom);
    req_rd[0] = 1'b1; apply_reqs();
    do_burst(3, 1'b1, 1'b0, '0);
    req_rd[0] = 1'b1; apply_reqs();
    sdr.r_vld = 1'b1; sdr.dout = 16'hBEEF; sdr.rd_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvld", 32'(m0.r_vld | m1.r_vld), 32'd0);
    chk("mid_rst_dout", 32'(m0.dout | m1.dout),   32'd0);
    chk("mid_rst_ack",  32'(m0.rd_ack | m1.rd_ack), 32'd0);
    chk("mid_rst_req",  32'(sdr.rd_req | sdr.we_req), 32'd0);
    chk("mid_rst_addr", 32'(sdr.addr), 32'd0);
    tick();
    clear_inputs();
    tick();
    rst_n = 1'b1;
    mdl_last = 1'b1;
    maddr[1] = AW'($urandom);
    req_we[1] = 1'b1; apply_reqs();
    do_burst(BL, 1'b1, 1'b0, '0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_fb_sdr_arbiter.md
Name: pb_fb_sdr_arbiter

Overview:
Two-master arbiter for the SDRAM controller burst command port (bst_rd/bst_we req/ack, addr, din/dout, r_vld, w_rdy). It shares the single DRAM controller between the L2 cache (master 0) and a second burst master such as a DMA or framebuffer reader (master 1). Grant is round-robin and locked for a whole burst. It sits on the sdr_clk domain, between the masters and pb_fb_DRAM_ctrl.

Parameters:
CMD_ADDR_WIDTH, 23, burst command address width
NL_DW, 16, SDRAM data beat width
BURST_LEN, 8, beats per burst (power of two, 2..256)

Ports:
clk  in  1  sdr_clk domain clock
rst_n  in  1  asynchronous active-low reset
mN_cmd_bst_rd_req  in  1  master N read burst request, level (N=0,1)
mN_cmd_bst_we_req  in  1  master N write burst request, level
mN_cmd_bst_rd_ack  out  1  master N read accept pulse
mN_cmd_bst_we_ack  out  1  master N write accept pulse
mN_cmd_addr  in  CMD_ADDR_WIDTH  master N burst address
mN_din  in  NL_DW  master N write beat data
mN_dout  out  NL_DW  read beat data (broadcast to both masters)
mN_r_vld  out  1  read beat valid to master N
mN_w_rdy  out  1  write beat consumed from master N
sdr_cmd_bst_rd_req  out  1  to DRAM ctrl
sdr_cmd_bst_we_req  out  1  to DRAM ctrl
sdr_cmd_bst_rd_ack  in  1  from DRAM ctrl
sdr_cmd_bst_we_ack  in  1  from DRAM ctrl
sdr_cmd_addr  out  CMD_ADDR_WIDTH  to DRAM ctrl
sdr_din  out  NL_DW  write data to DRAM ctrl
sdr_dout  in  NL_DW  read data from DRAM ctrl
sdr_r_vld  in  1  read beat valid
sdr_w_rdy  in  1  write beat taken

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, CMD, XFER. Reset puts the FSM in IDLE, grant=0, last=1 (master 0 wins first tie), beat_cnt=0, and dir=rd.
- Reset values: all acks, sdr reqs, r_vld and w_rdy outputs are 0. sdr_cmd_addr, sdr_din and dout are 0.
- IDLE: let reqN = mN_rd_req | mN_we_req.
  - If only one master requests, it is granted.
  - If both request, the master that is not `last` is granted.
  - On the same edge: grant is registered; dir is registered (rd if that master's rd_req is set, else we); the FSM moves to CMD.
  - No request: stay in IDLE.
  - A request seen in cycle N gives the downstream req in cycle N+1.
- CMD:
  - sdr_cmd_bst_{dir}_req = granted master's {dir}_req.
  - sdr_cmd_addr = granted master's addr (combinational mux).
  - The sdr ack of the matching dir is routed combinationally to the granted master only.
  - On ack: go to XFER, beat_cnt=0, last=grant.
  - If the granted master deasserts its req before ack, return to IDLE with no ack issued and last unchanged (abort).
- XFER:
  - mN_r_vld = sdr_r_vld & (grant==N) & dir==rd.
  - mN_w_rdy = sdr_w_rdy & (grant==N) & dir==we.
  - sdr_din = granted master's din.
  - Each beat (r_vld or w_rdy of dir) increments beat_cnt (width log2(BURST_LEN), wraps).
  - On the beat with beat_cnt==BURST_LEN-1: go to IDLE. This gives a one-cycle arbitration gap between bursts.
  - Requests are ignored in XFER. Non-granted masters see no vld, rdy or ack.
  - Beats are never dropped. Beat strobes outside XFER are ignored and are an assertion failure.
- Simultaneous rd_req and we_req from one master: read wins, and the write stays pending for a later arbitration.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1.
- Reset mid-burst: everything returns to reset state immediately. The DRAM controller is reset by the same rst_n.
- Assertions:
  - an ack in IDLE or XFER;
  - an ack of the wrong direction;
  - an sdr req high outside CMD.

Decomposition:
- Shared package/header (pb_fb_sdr_arbiter_defs):
  - FSM state encodings (IDLE=0, CMD=1, XFER=2);
  - dir encoding (RD=0, WE=1);
  - default CMD_ADDR_WIDTH and NL_DW.
- One sub-module: pb_fb_rr_arb2 (combinational 2-way round-robin pick from req[1:0] and last, returns the grant index).
- Muxes and FSM stay in the top.

Test Plan:
- Only m0 rd_req, addr=0x12345 -> sdr_cmd_bst_rd_req next cycle with addr 0x12345; ack pulse reaches m0 only; 8 sdr_r_vld beats of 0xA000..0xA007 reach m0_r_vld/dout; FSM back in IDLE after beat 8; m1_r_vld never high.
- m0 rd and m1 we requested in the same cycle after reset -> m0 granted first; then m1 gets sdr_cmd_bst_we_req with its addr; sdr_din follows m1_din across 8 w_rdy beats.
- Both masters request continuously for 6 bursts -> grant sequence 0,1,0,1,0,1; each burst completes 8 beats.
- m1 drops we_req in CMD before ack -> FSM returns to IDLE; no m1 ack; m0 pending request is granted next, per last rule.
- m0 asserts rd_req and we_req together -> read burst issued first; write issued on the following arbitration.
- rst_n pulled low after 3 of 8 beats -> all outputs 0 asynchronously; after release, a new m1 request is granted and runs a full 8 beats.
